// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, requester IDs and a
// counter-width helper.
package dmem_port_arbiter_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_BUSY = 2'd1;
  localparam logic [1:0] LD_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StCpuBusy = CPU_BUSY,
    StLdBusy  = LD_BUSY
  } arb_state_e;

  typedef enum logic {
    ReqCpu = 1'b0,
    ReqLd  = 1'b1
  } req_id_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_arb_fair_ctr.sv
// Fairness arbiter: CPU has priority, but the loader wins once the CPU has taken
// MaxCpuStreak consecutive grants while the loader was waiting.
module arb_fair_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxCpuStreak = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic cpu_req_i,
  input  logic ld_req_i,
  output logic gnt_cpu_o,
  output logic gnt_ld_o
);

  localparam int unsigned CntW = cnt_width(MaxCpuStreak);
  localparam logic [CntW-1:0] StreakMax = CntW'(MaxCpuStreak);

  logic [CntW-1:0] streak_q, streak_d;

  always_comb begin
    gnt_ld_o  = arb_en_i & ld_req_i & (~cpu_req_i | (streak_q == StreakMax));
    gnt_cpu_o = arb_en_i & cpu_req_i & ~gnt_ld_o;

    streak_d = streak_q;
    if (!ld_req_i || gnt_ld_o) begin
      streak_d = '0;
    end else if (gnt_cpu_o && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port sequencer: arbitrates CPU vs loader onto a req/ack memory port,
// stalls the pipeline while a CPU access is outstanding and aborts hung accesses.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_CPU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_valid,
  output logic                cpu_err,
  output logic                stall_o,
  input  logic                ld_req,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic [DATA_W/8-1:0] ld_wstrb,
  output logic [DATA_W-1:0]   ld_rdata,
  output logic                ld_done,
  output logic                ld_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                err_sticky,
  input  logic                err_clr
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned TmoW  = cnt_width(TIMEOUT - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [StrbW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic              cpu_err_q, cpu_err_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;
  logic              err_sticky_q, err_sticky_d;

  logic              arb_en, gnt_cpu, gnt_ld, finish;
  req_id_e           owner;

  // No grant in a completion-pulse cycle: that requester's access has just finished.
  assign arb_en = (state_q == StIdle) & ~cpu_valid_q & ~ld_done_q;

  arb_fair_ctr #(
    .MaxCpuStreak(MAX_CPU_STREAK)
  ) u_fair_ctr (
    .clk_i    (clk),
    .rst_i    (rst),
    .arb_en_i (arb_en),
    .cpu_req_i(cpu_req),
    .ld_req_i (ld_req),
    .gnt_cpu_o(gnt_cpu),
    .gnt_ld_o (gnt_ld)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    tmo_d        = tmo_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    cpu_valid_d  = 1'b0;
    cpu_err_d    = 1'b0;
    ld_done_d    = 1'b0;
    ld_err_d     = 1'b0;
    err_sticky_d = err_sticky_q & ~err_clr;
    owner        = (state_q == StLdBusy) ? ReqLd : ReqCpu;
    finish       = mem_ack | (tmo_q == TmoLast);

    unique case (state_q)
      StIdle: begin
        if (gnt_cpu) begin
          state_d     = StCpuBusy;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_wstrb_d = cpu_wstrb;
          tmo_d       = '0;
        end else if (gnt_ld) begin
          state_d     = StLdBusy;
          mem_req_d   = 1'b1;
          mem_we_d    = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          mem_wstrb_d = ld_wstrb;
          tmo_d       = '0;
        end
      end
      StCpuBusy, StLdBusy: begin
        if (finish) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          // An ack in the final timeout cycle still counts as a normal completion.
          if (owner == ReqCpu) begin
            cpu_valid_d = 1'b1;
            cpu_err_d   = ~mem_ack;
            if (!mem_ack) begin
              cpu_rdata_d = '0;
            end else if (!mem_we_q) begin
              cpu_rdata_d = mem_rdata;
            end
          end else begin
            ld_done_d = 1'b1;
            ld_err_d  = ~mem_ack;
            if (!mem_ack) begin
              ld_rdata_d = '0;
            end else if (!mem_we_q) begin
              ld_rdata_d = mem_rdata;
            end
          end
          if (!mem_ack) begin
            err_sticky_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      tmo_q        <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      cpu_valid_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_err_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      tmo_q        <= tmo_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_err_q    <= cpu_err_d;
      ld_done_q    <= ld_done_d;
      ld_err_q     <= ld_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_valid  = cpu_valid_q;
  assign cpu_err    = cpu_err_q;
  assign ld_rdata   = ld_rdata_q;
  assign ld_done    = ld_done_q;
  assign ld_err     = ld_err_q;
  assign err_sticky = err_sticky_q;
  assign stall_o    = cpu_req & ~cpu_valid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table of CPU accesses plus hand-written
// sequences for fairness, flush, timeout, stray ack and asynchronous reset.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_valid, cpu_err, stall_o;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic [3:0]  ld_wstrb;
  logic        ld_done, ld_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack, err_sticky, err_clr;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_CPU_STREAK(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_err(cpu_err),
    .stall_o(stall_o),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_wstrb(ld_wstrb), .ld_rdata(ld_rdata), .ld_done(ld_done), .ld_err(ld_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gnt_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_k;      // ack on this busy cycle (1 = zero-wait), 0 = never
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stall;
    int          exp_busy;
  } vec_t;

  resp_t cpu_q[$];
  resp_t ld_q[$];
  gnt_t  gnt_q[$];
  vec_t  vecs[6];

  int          checks = 0;
  int          failures = 0;
  int          ack_k = 1;
  int          busy_cnt = 0;
  int          last_busy = 0;
  logic [31:0] mem_data_v = 32'h0;
  bit          stray_ack = 1'b0;
  bit          mreq_prev = 1'b0;
  bit          unstable = 1'b0;
  logic [68:0] snap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock: monitor completions and grants, then update the memory model.
  task automatic cycle();
    resp_t r;
    gnt_t  g;
    @(posedge clk);
    #1;
    if (cpu_valid) begin
      if (cpu_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cpu_valid_unexpected actual=pulse required=none");
      end else begin
        r = cpu_q.pop_front();
        chk("cpu_rdata", cpu_rdata, r.rdata);
        chk("cpu_err", 32'(cpu_err), 32'(r.err));
      end
    end
    if (ld_done) begin
      if (ld_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ld_done_unexpected actual=pulse required=none");
      end else begin
        r = ld_q.pop_front();
        chk("ld_rdata", ld_rdata, r.rdata);
        chk("ld_err", 32'(ld_err), 32'(r.err));
      end
    end
    if (mem_req && !mreq_prev) begin
      unstable = 1'b0;
      snap = {mem_we, mem_addr, mem_wdata, mem_wstrb};
      if (gnt_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL grant_unexpected actual=addr 0x%0h required=no grant", mem_addr);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt_we", 32'(mem_we), 32'(g.we));
        chk("gnt_addr", mem_addr, g.addr);
        chk("gnt_wdata", mem_wdata, g.wdata);
        chk("gnt_wstrb", 32'(mem_wstrb), 32'(g.wstrb));
      end
    end else if (mem_req && ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== snap)) begin
      unstable = 1'b1;
    end
    if (!mem_req && mreq_prev) begin
      chk("mem_stable", 32'(unstable), 32'd0);
      last_busy = busy_cnt;
    end
    mreq_prev = mem_req;
    if (mem_req) begin
      busy_cnt++;
      mem_ack   = (ack_k != 0) && (busy_cnt == ack_k);
      mem_rdata = mem_data_v;
    end else begin
      busy_cnt  = 0;
      mem_ack   = stray_ack;
      mem_rdata = stray_ack ? 32'hFFFF_FFFF : 32'h0;
    end
  endtask

  task automatic cpu_access(input vec_t v);
    int n, stalls, mreq_cyc;
    bit done;
    n = 0; stalls = 0; mreq_cyc = -1; done = 1'b0;
    ack_k = v.ack_k;
    mem_data_v = v.mem_data;
    cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.wstrb;
    cpu_req = 1'b1;
    gnt_q.push_back('{v.we, v.addr, v.wdata, v.wstrb});
    cpu_q.push_back('{v.exp_rdata, v.exp_err});
    while (!done && n < 200) begin
      #1;
      if (stall_o) stalls++;
      cycle();
      n++;
      if (mem_req && mreq_cyc < 0) mreq_cyc = n;
      if (cpu_valid) done = 1'b1;
    end
    chk("cpu_done", 32'(done), 32'd1);
    chk("mem_req_lat", mreq_cyc, 1);
    chk("valid_lat", n, v.exp_stall);
    chk("stall_cycles", stalls, v.exp_stall);
    chk("busy_len", last_busy, v.exp_busy);
    #1;
    chk("stall_at_valid", 32'(stall_o), 32'd0);
    cpu_req = 1'b0;
    cycle();
  endtask

  // Returns in the ld_done cycle with ld_req already dropped.
  task automatic ld_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int k, input logic [31:0] md,
                           input logic [31:0] exp_rd, input logic exp_err);
    bit done;
    done = 1'b0;
    ack_k = k;
    mem_data_v = md;
    ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_wstrb = strb;
    ld_req = 1'b1;
    gnt_q.push_back('{we, addr, wdata, strb});
    ld_q.push_back('{exp_rd, exp_err});
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      if (ld_done) begin
        done = 1'b1;
        ld_req = 1'b0;
      end
    end
    chk("ld_done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ncpu, npulse;
    bit   stray_bad;

    vecs[0] = '{1'b0, 32'h100, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 1};
    vecs[1] = '{1'b1, 32'h200, 32'h1234_5678, 4'hF, 5, 32'h0, 32'hDEAD_BEEF, 1'b0, 6, 5};
    vecs[2] = '{1'b0, 32'h300, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4, 3};
    vecs[3] = '{1'b1, 32'h304, 32'hA5A5_A5A5, 4'h3, 1, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1};
    vecs[4] = '{1'b0, 32'h308, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 2};
    vecs[5] = '{1'b0, 32'h400, 32'h0, 4'hF, 0, 32'h1111_1111, 32'h0, 1'b1, 65, 64};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_wstrb = '0;
    mem_rdata = '0; mem_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b0;
    cycle();

    foreach (vecs[i]) cpu_access(vecs[i]);

    chk("err_sticky_set", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("err_sticky_clr", 32'(err_sticky), 32'd0);

    ld_access(1'b0, 32'h900, 32'h0, 4'hF, 2, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
    cycle();

    // Fairness: continuous CPU traffic with the loader waiting.
    ack_k = 1;
    mem_data_v = 32'h600D_0000;
    ld_we = 1'b1; ld_addr = 32'h800; ld_wdata = 32'h0000_BEEF; ld_wstrb = 4'hF; ld_req = 1'b1;
    cpu_we = 1'b0; cpu_wdata = 32'h0; cpu_wstrb = 4'hF; cpu_addr = 32'h500; cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back('{1'b0, 32'h500 + 32'(4 * i), 32'h0, 4'hF});
      cpu_q.push_back('{32'h600D_0000, 1'b0});
    end
    gnt_q.push_back('{1'b1, 32'h800, 32'h0000_BEEF, 4'hF});
    ld_q.push_back('{32'h1357_9BDF, 1'b0});
    gnt_q.push_back('{1'b0, 32'h510, 32'h0, 4'hF});
    cpu_q.push_back('{32'h600D_0000, 1'b0});
    ncpu = 0;
    for (int i = 0; i < 100 && (ncpu < 5 || ld_req); i++) begin
      cycle();
      if (ld_done) ld_req = 1'b0;
      if (cpu_valid) begin
        ncpu++;
        cpu_addr = 32'h500 + 32'(4 * ncpu);
        if (ncpu == 5) cpu_req = 1'b0;
      end
    end
    chk("fair_ncpu", ncpu, 5);
    chk("fair_gnt_drain", gnt_q.size(), 0);
    chk("fair_ld_drain", ld_q.size(), 0);
    cycle();

    // Flush: cpu_req drops the cycle after it was granted.
    ack_k = 2;
    mem_data_v = 32'h7777_8888;
    gnt_q.push_back('{1'b0, 32'h600, 32'h0, 4'hF});
    cpu_q.push_back('{32'h7777_8888, 1'b0});
    cpu_addr = 32'h600; cpu_req = 1'b1;
    cycle();
    cpu_req = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (cpu_valid) npulse++;
    end
    chk("flush_pulses", npulse, 1);
    chk("flush_gnt_drain", gnt_q.size(), 0);

    // Loader timeout while err_clr is held: the new error must still be recorded.
    err_clr = 1'b1;
    ld_access(1'b0, 32'hA00, 32'h0, 4'hF, 0, 32'h2222_2222, 32'h0, 1'b1);
    chk("sticky_set_wins", 32'(err_sticky), 32'd1);
    err_clr = 1'b0;
    cycle();

    // Stray ack while idle must not start or complete anything.
    stray_ack = 1'b1;
    stray_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (mem_req || cpu_valid || ld_done) stray_bad = 1'b1;
    end
    stray_ack = 1'b0;
    cycle();
    chk("stray_ack", 32'(stray_bad), 32'd0);

    // Asynchronous reset in the middle of a CPU access.
    ack_k = 0;
    gnt_q.push_back('{1'b0, 32'h700, 32'h0, 4'hF});
    cpu_addr = 32'h700; cpu_req = 1'b1;
    repeat (3) cycle();
    chk("rst_pre_busy", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_valid", 32'(cpu_valid), 32'd0);
    cpu_req = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    cpu_access('{1'b0, 32'h704, 32'h0, 4'hF, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 2, 1});

    repeat (3) cycle();
    chk("end_cpu_q", cpu_q.size(), 0);
    chk("end_ld_q", ld_q.size(), 0);
    chk("end_gnt_q", gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Sequences the data-memory port behind the execute/memory pipeline register. It arbitrates between the memory-stage CPU access and a program-loader/debug requester, drives a req/ack memory handshake, and generates the pipeline stall that holds the execute/memory register while an access is outstanding. A fairness counter bounds loader starvation, and a timeout converts a hung memory into a reported error.

Parameters:
ADDR_W, 32, address width for all ports
DATA_W, 32, data width; byte-strobe width is DATA_W/8
MAX_CPU_STREAK, 4, consecutive CPU grants allowed while the loader waits
TIMEOUT, 64, cycles in a busy state without mem_ack before the access is aborted

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_req  in  1  memory-stage access request (MemWriteM or a load in M)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  ALUResultM
cpu_wdata  in  DATA_W  WriteDataM
cpu_wstrb  in  DATA_W/8  byte enables
cpu_rdata  out  DATA_W  captured read data
cpu_valid  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_valid; access timed out
stall_o  out  1  hold execute/memory register and upstream stages
ld_req  in  1  loader request, held until ld_done
ld_we, ld_addr, ld_wdata, ld_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  loader access
ld_rdata  out  DATA_W  captured read data
ld_done  out  1  one-cycle completion pulse
ld_err  out  1  qualifies ld_done
mem_req  out  1  memory request, held until ack
mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered, stable while mem_req=1
mem_rdata  in  DATA_W  valid when mem_ack=1
mem_ack  in  1  one-cycle completion from memory
err_sticky  out  1  set on any timeout
err_clr  in  1  clears err_sticky

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 (mem_req drops mid-access, no completion pulse); streak and timeout counters 0.
- States: IDLE, CPU_BUSY, LD_BUSY.
- IDLE arbitration (registered grant): CPU wins unless ld_req=1 and streak==MAX_CPU_STREAK, in which case the loader wins. A cpu_req in the same cycle cpu_valid=1 is not re-granted; that request has just completed.
- Grant: on the next edge, latch the winner's we/addr/wdata/wstrb into mem_*, set mem_req=1, and enter the busy state. Timeout counter starts at 0.
- Busy: mem_* stay constant. On mem_ack: capture mem_rdata (reads only; writes leave rdata unchanged), drop mem_req, return to IDLE, and pulse cpu_valid or ld_done in the next cycle.
- Back-to-back: a new grant is earliest the cycle after the completion pulse.
- Streak: increments on a CPU grant while ld_req=1; resets to 0 on a loader grant or whenever ld_req=0; saturates at MAX_CPU_STREAK.
- Timeout: the counter reaches TIMEOUT-1 with no ack → drop mem_req, return to IDLE, pulse valid/done with err=1 and rdata=0, set err_sticky. If err_clr and a new timeout occur in the same cycle, set wins.
- A mem_ack while IDLE is ignored.
- stall_o = cpu_req & ~cpu_valid (combinational). Minimum CPU access latency with a zero-wait memory: req at N, mem_req at N+1, ack at N+1, cpu_valid at N+2, giving 2 stall cycles.
- A granted CPU access always completes, even if cpu_req drops (flush); the pulse is still generated and the pipeline ignores it.
- Loader must hold its inputs stable while ld_req=1 and until ld_done.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, CPU_BUSY=2'd1, LD_BUSY=2'd2) and requester IDs.
- One natural sub-module, arb_fair_ctr: streak counter plus grant decision, purely registered counter with a combinational grant output.

Test Plan:
- CPU read 0x100, memory acks 1 cycle after mem_req with 0xDEADBEEF → mem_req=1 at N+1, cpu_valid and cpu_rdata=0xDEADBEEF at N+2, stall_o=1 at N and N+1, 0 at N+2.
- CPU write 0x200 data 0x12345678 wstrb=0xF, ack delayed 5 cycles → mem_* stable for all 5 cycles, one cpu_valid pulse, stall_o=1 for 6 cycles.
- ld_req held with continuous cpu_req, MAX_CPU_STREAK=4 → grant order is 4 CPU accesses, then 1 loader access (ld_done pulses), then CPU again.
- No ack, TIMEOUT=64 → mem_req drops after 64 busy cycles, cpu_valid=1, cpu_err=1, cpu_rdata=0, err_sticky=1; err_clr then clears it.
- rst asserted mid CPU_BUSY → mem_req=0 immediately with no cpu_valid; after release, a fresh request completes normally.
- cpu_req drops in cycle N+1 of a granted read → access still completes, cpu_valid pulses once, and no second grant occurs.
